// File: rtl/touch_pkg.sv
// Shared FSM encoding and default qualification counts for the touch pad conditioner.
package touch_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'h0,
        PRESS_QUAL   = 2'h1,
        PRESSED      = 2'h2,
        RELEASE_QUAL = 2'h3
    } state_t;

    localparam int DEF_CNT_WIDTH      = 16;
    localparam int DEF_PRESS_CYCLES   = 18000;
    localparam int DEF_RELEASE_CYCLES = 18000;

endpackage

// File: rtl/touch_sync.sv
// Two-flop synchroniser bringing the raw pad level into the clk domain.
// Latency: 2 cycles; no backpressure, samples every cycle.
module touch_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s0 <= d;
            q  <= s0;
        end
    end

endmodule

// File: rtl/touch_debounce.sv
// Debounces the touch pad into a clean registered touch_event level.
// Latency: PRESS_CYCLES+3 edges to assert, RELEASE_CYCLES+3 to clear; no backpressure.
module touch_debounce
    import touch_pkg::*;
#(
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int PRESS_CYCLES   = DEF_PRESS_CYCLES,
    parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic touch_pad,
    input  logic enable,
    output logic touch_event,
    output logic qualifying
);

    localparam logic [CNT_WIDTH-1:0] PRESS_LAST   = CNT_WIDTH'(PRESS_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RELEASE_LAST = CNT_WIDTH'(RELEASE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    logic                 pad_act;
    logic                 sync_s1;
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;

    assign pad_act = ACTIVE_LOW ? ~touch_pad : touch_pad;

    touch_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pad_act),
        .q     (sync_s1)
    );

    // Outputs are assigned alongside each state transition so they reflect the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            touch_event <= 1'b0;
            qualifying  <= 1'b0;
        end else if (!enable) begin
            state       <= IDLE;
            cnt         <= '0;
            touch_event <= 1'b0;
            qualifying  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    touch_event <= 1'b0;
                    if (sync_s1) begin
                        state      <= PRESS_QUAL;
                        cnt        <= '0;
                        qualifying <= 1'b1;
                    end else begin
                        qualifying <= 1'b0;
                    end
                end
                PRESS_QUAL: begin
                    if (!sync_s1) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        touch_event <= 1'b0;
                        qualifying  <= 1'b0;
                    end else if (cnt == PRESS_LAST) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        touch_event <= 1'b1;
                        qualifying  <= 1'b0;
                    end else begin
                        cnt         <= cnt + CNT_ONE;
                        touch_event <= 1'b0;
                        qualifying  <= 1'b1;
                    end
                end
                PRESSED: begin
                    touch_event <= 1'b1;
                    if (!sync_s1) begin
                        state      <= RELEASE_QUAL;
                        cnt        <= '0;
                        qualifying <= 1'b1;
                    end else begin
                        qualifying <= 1'b0;
                    end
                end
                RELEASE_QUAL: begin
                    if (sync_s1) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        touch_event <= 1'b1;
                        qualifying  <= 1'b0;
                    end else if (cnt == RELEASE_LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        touch_event <= 1'b0;
                        qualifying  <= 1'b0;
                    end else begin
                        cnt         <= cnt + CNT_ONE;
                        touch_event <= 1'b1;
                        qualifying  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    touch_event <= 1'b0;
                    qualifying  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_touch_debounce.sv
// Directed vector bench for touch_debounce with PRESS_CYCLES=4, RELEASE_CYCLES=3.
module tb_touch_debounce;

    typedef struct {
        logic pad;
        logic en;
        logic exp_te;
        logic exp_q;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic pad_a;
    logic pad_b;
    logic enable;
    logic te_a, q_a, te_b, q_b;

    int n_vec = 0;
    int n_err = 0;

    vec_t vecs[$];

    touch_debounce #(.CNT_WIDTH(16), .PRESS_CYCLES(4), .RELEASE_CYCLES(3), .ACTIVE_LOW(1'b0)) dut_hi (
        .clk         (clk),
        .reset       (reset),
        .touch_pad   (pad_a),
        .enable      (enable),
        .touch_event (te_a),
        .qualifying  (q_a)
    );

    touch_debounce #(.CNT_WIDTH(16), .PRESS_CYCLES(4), .RELEASE_CYCLES(3), .ACTIVE_LOW(1'b1)) dut_lo (
        .clk         (clk),
        .reset       (reset),
        .touch_pad   (pad_b),
        .enable      (enable),
        .touch_event (te_b),
        .qualifying  (q_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic pad, input logic en, input logic te, input logic q, input int n);
        vec_t v;
        v.pad = pad; v.en = en; v.exp_te = te; v.exp_q = q;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // clean press then release
        add(1, 1, 0, 0, 2); add(1, 1, 0, 1, 4); add(1, 1, 1, 0, 2);
        add(0, 1, 1, 0, 2); add(0, 1, 1, 1, 3); add(0, 1, 0, 0, 2);
        // glitch of 3 cycles rejected
        add(1, 1, 0, 0, 2); add(1, 1, 0, 1, 1); add(0, 1, 0, 1, 2); add(0, 1, 0, 0, 2);
        // press, then 2-cycle dip absorbed, then real release
        add(1, 1, 0, 0, 2); add(1, 1, 0, 1, 4); add(1, 1, 1, 0, 2);
        add(0, 1, 1, 0, 2); add(1, 1, 1, 1, 1); add(0, 1, 1, 1, 1); add(0, 1, 1, 0, 1);
        add(0, 1, 1, 1, 3); add(0, 1, 0, 0, 2);
        // enable override, requalify, enable beats completing qualification
        add(1, 1, 0, 0, 2); add(1, 1, 0, 1, 4); add(1, 1, 1, 0, 2);
        add(1, 0, 0, 0, 1); add(1, 1, 0, 1, 4); add(1, 1, 1, 0, 1);
        add(1, 0, 0, 0, 1); add(1, 1, 0, 1, 4); add(1, 0, 0, 0, 1);
        add(1, 1, 0, 1, 4); add(1, 1, 1, 0, 1);
        add(0, 1, 1, 0, 2); add(0, 1, 1, 1, 3); add(0, 1, 0, 0, 1);

        reset = 1'b1; pad_a = 1'b0; pad_b = 1'b1; enable = 1'b1;
        #12;
        check("reset_te", 0, te_a, 1'b0);
        check("reset_q", 0, q_a, 1'b0);
        check("reset_te_lo", 0, te_b, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            pad_a  = vecs[i].pad;
            enable = vecs[i].en;
            tick();
            check("vec_te", i, te_a, vecs[i].exp_te);
            check("vec_q", i, q_a, vecs[i].exp_q);
            check("vec_te_lo_idle", i, te_b, 1'b0);
        end

        // async reset during PRESS_QUAL
        @(negedge clk);
        pad_a = 1'b1;
        repeat (4) tick();
        check("pq_before_rst", 0, q_a, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_pq_te", 0, te_a, 1'b0);
        check("rst_pq_q", 0, q_a, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) check("post_rst1_e6", k, te_a, 1'b0);
            if (k == 7) check("post_rst1_e7", k, te_a, 1'b1);
        end

        // async reset while PRESSED
        tick();
        check("pressed_before_rst", 0, te_a, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_pr_te", 0, te_a, 1'b0);
        check("rst_pr_q", 0, q_a, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) check("post_rst2_e6", k, te_a, 1'b0);
            if (k == 7) check("post_rst2_e7", k, te_a, 1'b1);
        end

        // active-low pad: press by driving low, release by returning high
        @(negedge clk);
        pad_b = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) check("lo_press_e6", k, te_b, 1'b0);
            if (k == 7) check("lo_press_e7", k, te_b, 1'b1);
        end
        @(negedge clk);
        pad_b = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) check("lo_rel_e5", k, te_b, 1'b1);
            if (k == 6) check("lo_rel_e6", k, te_b, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
